// File: rtl/fmcw_frontend_ctrl.sv
// FMCW radar front-end controller: programs the ADF4158 over its 3-wire bus after reset,
// then registers offset-binary ADC samples as two's complement and emits a periodic sample enable.
module fmcw_frontend_ctrl #(
    parameter int unsigned    ADC_DATA_WIDTH = 12,
    parameter int unsigned    SCLK_HALF      = 2,
    parameter int unsigned    STARTUP_CYCLES = 8,
    parameter int unsigned    CE_DIV         = 20,
    parameter logic [319:0]   CFG_WORDS      = {
        32'h00000007, 32'h0000A006, 32'h0080A006, 32'h00500005, 32'h00800005,
        32'h00180104, 32'h00000043, 32'h0010800A, 32'h00000001, 32'h812C8000
    }
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      adf_ce_o,
    output logic                      adf_le_o,
    output logic                      adf_clk_o,
    output logic                      adf_data_o,
    output logic                      adf_txdata_o,
    input  logic                      adf_muxout_i,
    output logic                      muxout_o,
    output logic                      config_done_o,
    input  logic [ADC_DATA_WIDTH-1:0] adc_d_i,
    input  logic                      adc_of_i,
    output logic [ADC_DATA_WIDTH-1:0] chan_a_o,
    output logic                      adc_of_o,
    output logic                      ce_2mhz_o
);

    localparam int unsigned NUM_WORDS = 10;
    localparam int unsigned BIT_CYC   = 2 * SCLK_HALF;
    localparam int unsigned CNT_MAX   = (STARTUP_CYCLES > BIT_CYC) ? STARTUP_CYCLES : BIT_CYC;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
    localparam int unsigned CE_W      = $clog2(CE_DIV);

    typedef enum logic [1:0] {
        S_WAIT,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [4:0]                  bit_q, bit_d;
    logic [3:0]                  word_q, word_d;
    logic                        data_q, data_d;
    logic                        sync1_q, sync1_d;
    logic                        sync2_q, sync2_d;
    logic [ADC_DATA_WIDTH-1:0]   chan_q, chan_d;
    logic                        of_q, of_d;
    logic [CE_W-1:0]             ce_cnt_q, ce_cnt_d;
    logic                        ce_q, ce_d;

    // Word 0 occupies the top 32 bits of CFG_WORDS.
    function automatic logic cfg_bit(input logic [3:0] word, input logic [4:0] bitn);
        logic [8:0] idx;
        idx = 9'((NUM_WORDS - 1 - 32'(word)) * 32 + 32'(bitn));
        return CFG_WORDS[idx];
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        word_d   = word_q;
        data_d   = data_q;

        case (state_q)
            S_WAIT: begin
                if (cnt_q == CNT_W'(STARTUP_CYCLES - 1)) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = 5'd31;
                    word_d  = '0;
                    data_d  = cfg_bit(4'd0, 5'd31);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (cnt_q == CNT_W'(BIT_CYC - 1)) begin
                    cnt_d = '0;
                    if (bit_q == 5'd0) begin
                        state_d = S_LATCH;
                        data_d  = 1'b0;
                    end else begin
                        bit_d  = bit_q - 5'd1;
                        data_d = cfg_bit(word_q, bit_q - 5'd1);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (cnt_q == CNT_W'(BIT_CYC - 1)) begin
                    cnt_d = '0;
                    if (word_q == 4'(NUM_WORDS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SHIFT;
                        word_d  = word_q + 4'd1;
                        bit_d   = 5'd31;
                        data_d  = cfg_bit(word_q + 4'd1, 5'd31);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE:  ;
            default: state_d = S_WAIT;
        endcase

        sync1_d = adf_muxout_i;
        sync2_d = sync1_q;

        chan_d = (state_q == S_DONE) ? {~adc_d_i[ADC_DATA_WIDTH-1], adc_d_i[ADC_DATA_WIDTH-2:0]} : '0;
        of_d   = of_q | (adc_of_i & (state_q == S_DONE));

        ce_d     = (ce_cnt_q == CE_W'(CE_DIV - 1));
        ce_cnt_d = ce_d ? '0 : ce_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_WAIT;
            cnt_q    <= '0;
            bit_q    <= '0;
            word_q   <= '0;
            data_q   <= 1'b0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            chan_q   <= '0;
            of_q     <= 1'b0;
            ce_cnt_q <= '0;
            ce_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            word_q   <= word_d;
            data_q   <= data_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            chan_q   <= chan_d;
            of_q     <= of_d;
            ce_cnt_q <= ce_cnt_d;
            ce_q     <= ce_d;
        end
    end

    assign adf_ce_o      = 1'b1;
    assign adf_txdata_o  = 1'b0;
    assign adf_le_o      = (state_q != S_SHIFT);
    assign adf_clk_o     = (state_q == S_SHIFT) && (cnt_q >= CNT_W'(SCLK_HALF));
    assign adf_data_o    = data_q;
    assign config_done_o = (state_q == S_DONE);
    assign muxout_o      = sync2_q;
    assign chan_a_o      = chan_q;
    assign adc_of_o      = of_q;
    assign ce_2mhz_o     = ce_q;

endmodule

// File: tb/tb_fmcw_frontend_ctrl.sv
// Self-checking bench for fmcw_frontend_ctrl: a cycle-count based model of the expected
// bus waveform, ADC path, synchronizer and clock enable, plus directed literal checks.
module tb_fmcw_frontend_ctrl;

    localparam int DONE_T  = 1328;
    localparam int START_T = 8;
    localparam int WORD_T  = 132;
    localparam int SHIFT_T = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        adf_ce_o, adf_le_o, adf_clk_o, adf_data_o, adf_txdata_o;
    logic        adf_muxout_i = 1'b0;
    logic        muxout_o, config_done_o;
    logic [11:0] adc_d_i = '0;
    logic        adc_of_i = 1'b0;
    logic [11:0] chan_a_o;
    logic        adc_of_o, ce_2mhz_o;

    fmcw_frontend_ctrl #(
        .ADC_DATA_WIDTH(12),
        .SCLK_HALF(2),
        .STARTUP_CYCLES(8),
        .CE_DIV(20)
    ) dut (
        .clk(clk), .rst(rst),
        .adf_ce_o(adf_ce_o), .adf_le_o(adf_le_o), .adf_clk_o(adf_clk_o),
        .adf_data_o(adf_data_o), .adf_txdata_o(adf_txdata_o),
        .adf_muxout_i(adf_muxout_i), .muxout_o(muxout_o),
        .config_done_o(config_done_o),
        .adc_d_i(adc_d_i), .adc_of_i(adc_of_i),
        .chan_a_o(chan_a_o), .adc_of_o(adc_of_o), .ce_2mhz_o(ce_2mhz_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                      name, act, act, exp, exp, $time);
    endtask

    bit [31:0] cfg_tab [10] = '{
        32'h00000007, 32'h0000A006, 32'h0080A006, 32'h00500005, 32'h00800005,
        32'h00180104, 32'h00000043, 32'h0010800A, 32'h00000001, 32'h812C8000
    };

    // Model state: m_t counts clock edges since the last reset edge.
    int        m_t = 0;
    bit        started = 0;
    int        m_chan = 0;
    bit        m_of = 0, m1 = 0, m2 = 0;
    bit [31:0] shreg = '0;
    bit [31:0] words[$];
    int        first_rise = -1;
    int        done_t = -1;
    logic      prev_clk = 1'b0, prev_le = 1'b1, prev_done = 1'b0;

    initial begin : monitor
        logic        r, o, mi;
        logic [11:0] d;
        bit          done_b, e_le, e_clk, e_data, data_valid;
        int          u, w, ph;
        bit [31:0]   wv;
        forever begin
            @(posedge clk);
            r = rst; d = adc_d_i; o = adc_of_i; mi = adf_muxout_i;
            #1;
            if (r) begin
                started = 1; m_t = 0; m_chan = 0; m_of = 0; m1 = 0; m2 = 0;
                words.delete(); first_rise = -1; done_t = -1; shreg = '0;
            end else if (started) begin
                done_b = (m_t >= DONE_T);
                m_chan = done_b ? int'(d) - 2048 : 0;
                m_of   = m_of | (o & done_b);
                m2 = m1; m1 = mi;
                m_t++;
            end
            if (started) begin
                e_le = 1'b1; e_clk = 1'b0; e_data = 1'b0; data_valid = 1'b0;
                if (m_t < START_T) begin
                    data_valid = 1'b1;
                end else if (m_t < DONE_T) begin
                    u = m_t - START_T; w = u / WORD_T; ph = u % WORD_T;
                    if (ph < SHIFT_T) begin
                        wv = cfg_tab[w];
                        e_le = 1'b0;
                        e_clk = ((ph % 4) >= 2);
                        e_data = wv[31 - ph / 4];
                        data_valid = 1'b1;
                    end
                end
                check("adf_ce", adf_ce_o, 1);
                check("adf_txdata", adf_txdata_o, 0);
                check("adf_le", adf_le_o, e_le);
                check("adf_clk", adf_clk_o, e_clk);
                if (data_valid) check("adf_data", adf_data_o, e_data);
                check("config_done", config_done_o, (m_t >= DONE_T));
                check("ce_2mhz", ce_2mhz_o, (m_t > 0 && m_t % 20 == 0));
                check("chan_a", $signed(chan_a_o), m_chan);
                check("adc_of", adc_of_o, m_of);
                check("muxout", muxout_o, m2);
                if (!r) begin
                    if (!prev_clk && adf_clk_o) begin
                        shreg = {shreg[30:0], adf_data_o};
                        if (first_rise < 0) first_rise = m_t;
                    end
                    if (!prev_le && adf_le_o) words.push_back(shreg);
                    if (!prev_done && config_done_o) done_t = m_t;
                end
                prev_clk = adf_clk_o; prev_le = adf_le_o; prev_done = config_done_o;
            end
        end
    end

    task automatic check_words();
        check("n_words", words.size(), 10);
        for (int i = 0; i < words.size() && i < 10; i++) check("word", int'(words[i]), int'(cfg_tab[i]));
        if (words.size() > 0) check("first_word", int'(words[0]), 32'h00000007);
        if (words.size() > 9) check("last_word", int'(words[9]), 32'h812C8000);
    endtask

    task automatic wait_done();
        int bound;
        bound = 0;
        while (!config_done_o && bound < 2000) begin
            @(negedge clk);
            adc_d_i = 12'($urandom_range(0, 4095));
            adc_of_i = 1'b0;
            @(posedge clk); #2;
            bound++;
        end
        check("done_timeout", config_done_o, 1);
    endtask

    typedef struct { logic [11:0] d; int exp; } adc_vec_t;
    adc_vec_t adc_vecs[5] = '{
        '{12'h000, -2048}, '{12'h800, 0}, '{12'hFFF, 2047}, '{12'h123, -1757}, '{12'h7FF, -1}
    };

    initial begin : stim
        int ce_n, first_ce, last_ce, bad_space;
        logic mval;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        ce_n = 0; first_ce = -1; last_ce = -1; bad_space = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk); #2;
            if (i < START_T) check("chan_before_done", $signed(chan_a_o), 0);
            if (ce_2mhz_o) begin
                if (last_ce >= 0 && i - last_ce != 20) bad_space++;
                if (first_ce < 0) first_ce = i;
                last_ce = i; ce_n++;
            end
            @(negedge clk);
            adc_d_i = 12'($urandom_range(0, 4095));
            adc_of_i = 1'($urandom_range(0, 1));
            if (i % 7 == 0) adf_muxout_i = ~adf_muxout_i;
        end
        check("ce_count", ce_n, 10);
        check("ce_first", first_ce, 20);
        check("ce_spacing", bad_space, 0);

        wait_done();
        check("first_sclk_rise", first_rise, 10);
        check("done_time", done_t, DONE_T);
        check_words();

        foreach (adc_vecs[k]) begin
            @(negedge clk); adc_d_i = adc_vecs[k].d;
            @(posedge clk); #2;
            check("chan_vec", $signed(chan_a_o), adc_vecs[k].exp);
        end

        check("adc_of_clear", adc_of_o, 0);
        @(negedge clk); adc_of_i = 1'b1;
        @(negedge clk); adc_of_i = 1'b0;
        repeat (6) @(posedge clk);
        #2 check("adc_of_sticky", adc_of_o, 1);

        @(negedge clk); mval = ~adf_muxout_i; adf_muxout_i = mval;
        @(posedge clk); #2 check("muxout_1cyc", muxout_o, !mval);
        @(posedge clk); #2 check("muxout_2cyc", muxout_o, mval);

        @(negedge clk); rst = 1'b1;
        @(posedge clk); #2;
        check("rst_of", adc_of_o, 0);
        check("rst_done", config_done_o, 0);
        check("rst_chan", $signed(chan_a_o), 0);
        @(negedge clk); rst = 1'b0;
        repeat (560) @(posedge clk);
        #2;
        check("words_before_rst", words.size(), 4);
        check("mid_word_le", adf_le_o, 0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #2;
        check("rst_mid_le", adf_le_o, 1);
        check("rst_mid_clk", adf_clk_o, 0);
        @(negedge clk); rst = 1'b0;

        wait_done();
        check("first_sclk_rise_2", first_rise, 10);
        check("done_time_2", done_t, DONE_T);
        check_words();

        repeat (3) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
